// File: rtl/shft_pkg.sv
// -----------------------------------------------------------------------------
// shft_pkg
// Shared definitions for the burst shift register slice: the shift-mode
// encodings seen on the mode input and the two-state burst FSM encoding.
// No ports; imported by shft_step and shft_burst_reg.
// -----------------------------------------------------------------------------
package shft_pkg;

  // Shift mode as presented on the mode input and latched at burst start
  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ROL = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  // Burst controller states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage : shft_pkg

// File: rtl/shft_step.sv
// -----------------------------------------------------------------------------
// shft_step
// Purely combinational single-step shifter. Given the current register value,
// a shift mode and a serial fill bit, produces the value after one shift and
// the bit that falls off the end.
//
// Parameters:
//   WIDTH       data width in bits (>= 2)
// Ports:
//   q_i         current register value
//   mode_i      shift mode (LSL/LSR/ROL/ROR)
//   sin_i       fill bit, used by the logical modes only
//   q_next_o    register value after one shift
//   bit_out_o   bit shifted out of the register
// -----------------------------------------------------------------------------
module shft_step
  import shft_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  shift_mode_e      mode_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic             bit_out_o
);

  // Rotates recirculate the outgoing bit; logical shifts pull in sin_i
  always_comb begin
    q_next_o  = q_i;
    bit_out_o = 1'b0;
    case (mode_i)
      MODE_LSL: begin
        bit_out_o = q_i[WIDTH-1];
        q_next_o  = {q_i[WIDTH-2:0], sin_i};
      end
      MODE_LSR: begin
        bit_out_o = q_i[0];
        q_next_o  = {sin_i, q_i[WIDTH-1:1]};
      end
      MODE_ROL: begin
        bit_out_o = q_i[WIDTH-1];
        q_next_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      end
      MODE_ROR: begin
        bit_out_o = q_i[0];
        q_next_o  = {q_i[0], q_i[WIDTH-1:1]};
      end
      default: begin
        q_next_o  = q_i;
        bit_out_o = 1'b0;
      end
    endcase
  end

endmodule : shft_step

// File: rtl/shft_burst_reg.sv
// -----------------------------------------------------------------------------
// shft_burst_reg
// Parallel-load shift register with a self-timed burst engine. A start in
// IDLE latches a mode and shift count, then one shift is performed per clock
// until the count runs out (done pulse) or abort is seen (no done pulse).
//
// Parameters:
//   WIDTH        data width in bits (>= 2)
//   CNT_W        width of the shift count input
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   load_i       parallel load strobe (IDLE only, wins over start_i)
//   ld_data_i    parallel load value
//   start_i      launch a burst (IDLE only)
//   mode_i       shift mode, latched at start
//   shift_num_i  number of shifts in the burst, latched at start
//   sin_i        serial fill bit for logical shifts, sampled every shift
//   abort_i      terminate a running burst without a done pulse
//   q_o          register contents
//   cout_o       last bit shifted out
//   busy_o       burst in progress
//   done_o       one-cycle pulse when a burst completes
//   parity_o     even parity of q_o (only when SHFT_PARITY_EN is defined)
//
// Build option: define SHFT_PARITY_EN to add the registered parity_o output.
// -----------------------------------------------------------------------------
module shft_burst_reg
  import shft_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] ld_data_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] shift_num_i,
  input  logic             sin_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] q_o,
  output logic             cout_o,
  output logic             busy_o,
`ifdef SHFT_PARITY_EN
  output logic             done_o,
  output logic             parity_o
`else
  output logic             done_o
`endif
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  shift_state_e     state_q;
  shift_mode_e      mode_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] data_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] data_d;
  logic             cout_d;
`ifdef SHFT_PARITY_EN
  logic             parity_q;
`endif

  // One shift of the current contents using the mode latched at start
  shft_step #(
    .WIDTH(WIDTH)
  ) uStep (
    .q_i      (data_q),
    .mode_i   (mode_q),
    .sin_i    (sin_i),
    .q_next_o (data_d),
    .bit_out_o(cout_d)
  );

  // Burst FSM with all outputs registered. An abort in SHIFT takes priority
  // over the shift on that edge, including the final one, so an aborted burst
  // never produces done and keeps its partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_LSL;
      count_q  <= '0;
      data_q   <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SHFT_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_i) begin
            data_q   <= ld_data_i;
`ifdef SHFT_PARITY_EN
            parity_q <= ^ld_data_i;
`endif
          end else if (start_i) begin
            if (shift_num_i != '0) begin
              mode_q  <= shift_mode_e'(mode_i);
              count_q <= shift_num_i;
              busy_q  <= 1'b1;
              state_q <= ST_SHIFT;
            end else begin
              // Zero-length burst completes immediately without going busy
              done_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (abort_i) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            data_q   <= data_d;
            cout_q   <= cout_d;
            count_q  <= count_q - CntOne;
`ifdef SHFT_PARITY_EN
            parity_q <= ^data_d;
`endif
            if (count_q == CntOne) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign q_o      = data_q;
  assign cout_o   = cout_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
`ifdef SHFT_PARITY_EN
  assign parity_o = parity_q;
`endif

endmodule : shft_burst_reg
